// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU op-code constants, sequencer state encoding and helpers
//               shared by the ALU and the wide sequencer front end.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_op_and    = 4'd0;
    localparam logic [3:0] c_op_or     = 4'd1;
    localparam logic [3:0] c_op_add    = 4'd2;
    localparam logic [3:0] c_op_not    = 4'd5;
    localparam logic [3:0] c_op_xor    = 4'd7;
    localparam logic [3:0] c_op_lshift = 4'd8;
    localparam logic [3:0] c_op_rshift = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERR   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // True for every code the ALU implements.
    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            c_op_and, c_op_or, c_op_add, c_op_not,
            c_op_xor, c_op_lshift, c_op_rshift: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // True for codes whose flag must ripple from slice to slice.
    function automatic logic op_chained(input logic [3:0] op);
        return (op == c_op_add) || (op == c_op_lshift) || (op == c_op_rshift);
    endfunction

    // Width of a slice index; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice_mux.sv
`default_nettype none
// ============================================================================
// Module      : alu_slice_mux
// Description : Reads slice i_sel of a wide vector and returns the same vector
//               with slice i_sel replaced by i_wr_slice.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_slice_mux
    import alu_pkg::*;
#(
    parameter int ancho    = 4,
    parameter int palabras = 4
) (
    input  logic [ancho*palabras-1:0]      i_vec,
    input  logic [idx_width(palabras)-1:0] i_sel,
    input  logic [ancho-1:0]               i_wr_slice,
    output logic [ancho-1:0]               o_slice,
    output logic [ancho*palabras-1:0]      o_vec
);

    logic [ancho-1:0] w_slices [palabras];

    for (genvar k = 0; k < palabras; k++) begin : g_slice
        assign w_slices[k]               = i_vec[k*ancho +: ancho];
        assign o_vec[k*ancho +: ancho]   = (int'(i_sel) == k) ? i_wr_slice : w_slices[k];
    end

    assign o_slice = w_slices[i_sel];

endmodule
`default_nettype wire

// File: rtl/alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_wide_sequencer
// Description : Splits one wide request into ancho-bit slices, issues them to
//               a combinational ALU one per cycle with the flag chained, and
//               returns the assembled result over a response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int ancho    = 4,
    parameter int palabras = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [3:0]                req_op,
    input  logic [ancho*palabras-1:0] req_a,
    input  logic [ancho*palabras-1:0] req_b,
    input  logic                      req_flag,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ancho*palabras-1:0] resp_result,
    output logic                      resp_flag,
    output logic                      resp_err,
    output logic [ancho-1:0]          alu_a,
    output logic [ancho-1:0]          alu_b,
    output logic                      alu_flag_in,
    output logic [3:0]                alu_control,
    input  logic [ancho-1:0]          alu_result,
    input  logic                      alu_flags
);

    localparam int              c_w    = ancho * palabras;
    localparam int              c_iw   = idx_width(palabras);
    localparam logic [c_iw-1:0] c_last = c_iw'(palabras - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    logic [3:0]        r_op;
    logic [c_w-1:0]    r_a;
    logic [c_w-1:0]    r_b;
    logic [c_w-1:0]    r_result;
    logic [c_iw-1:0]   r_idx;
    logic              r_flag;
    logic              r_err;
    logic [ancho-1:0]  r_alu_a;
    logic [ancho-1:0]  r_alu_b;
    logic              r_alu_flag_in;
    logic [3:0]        r_alu_control;

    logic              w_idle;
    logic              w_last;
    logic              w_chained;
    logic [3:0]        w_op_src;
    logic [c_iw-1:0]   w_idx_nxt;
    logic [c_iw-1:0]   w_nxt_sel;
    logic [c_iw-1:0]   w_cur_sel;
    logic [c_w-1:0]    w_src_a;
    logic [c_w-1:0]    w_src_b;
    logic [c_w-1:0]    w_result_wr;
    logic [ancho-1:0]  w_nxt_a;
    logic [ancho-1:0]  w_nxt_b;
    logic [ancho-1:0]  w_res_slice_unused;
    logic [c_w-1:0]    w_a_vec_unused;
    logic [c_w-1:0]    w_b_vec_unused;

    // Right shifts walk the slices from the top down.
    function automatic logic [c_iw-1:0] map_slice(input logic [c_iw-1:0] idx,
                                                  input logic [3:0]      op);
        return (op == c_op_rshift) ? (c_last - idx) : idx;
    endfunction

    // While idle the first slice is taken straight from the request so that
    // the ALU registers hold slice 0 in the very first ISSUE cycle.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_last    = (r_idx == c_last);
    assign w_chained = op_chained(r_op);
    assign w_op_src  = w_idle ? req_op : r_op;
    assign w_src_a   = w_idle ? req_a  : r_a;
    assign w_src_b   = w_idle ? req_b  : r_b;
    assign w_idx_nxt = (w_idle || w_last) ? '0 : (r_idx + 1'b1);
    assign w_nxt_sel = map_slice(w_idx_nxt, w_op_src);
    assign w_cur_sel = map_slice(r_idx, r_op);

    alu_slice_mux #(.ancho(ancho), .palabras(palabras)) u_mux_a (
        .i_vec      (w_src_a),
        .i_sel      (w_nxt_sel),
        .i_wr_slice ('0),
        .o_slice    (w_nxt_a),
        .o_vec      (w_a_vec_unused)
    );

    alu_slice_mux #(.ancho(ancho), .palabras(palabras)) u_mux_b (
        .i_vec      (w_src_b),
        .i_sel      (w_nxt_sel),
        .i_wr_slice ('0),
        .o_slice    (w_nxt_b),
        .o_vec      (w_b_vec_unused)
    );

    alu_slice_mux #(.ancho(ancho), .palabras(palabras)) u_mux_res (
        .i_vec      (r_result),
        .i_sel      (w_cur_sel),
        .i_wr_slice (alu_result),
        .o_slice    (w_res_slice_unused),
        .o_vec      (w_result_wr)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = op_supported(req_op) ? ST_ISSUE : ST_ERR;
            end
            ST_ISSUE: if (w_last) w_state_nxt = ST_DONE;
            ST_ERR:   w_state_nxt = ST_DONE;
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, slice issue, result assembly and flag chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_idx         <= '0;
            r_flag        <= 1'b0;
            r_err         <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_flag_in <= 1'b0;
            r_alu_control <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_op     <= req_op;
                    r_a      <= req_a;
                    r_b      <= req_b;
                    r_idx    <= '0;
                    r_result <= '0;
                    r_flag   <= 1'b0;
                    r_err    <= 1'b0;
                    if (op_supported(req_op)) begin
                        r_alu_a       <= w_nxt_a;
                        r_alu_b       <= w_nxt_b;
                        r_alu_flag_in <= op_chained(req_op) ? req_flag : 1'b0;
                        r_alu_control <= req_op;
                    end
                end
                ST_ISSUE: begin
                    r_result <= w_result_wr;
                    r_flag   <= w_chained ? alu_flags : 1'b0;
                    r_idx    <= w_idx_nxt;
                    if (w_last) begin
                        r_alu_a       <= '0;
                        r_alu_b       <= '0;
                        r_alu_flag_in <= 1'b0;
                        r_alu_control <= '0;
                    end else begin
                        r_alu_a       <= w_nxt_a;
                        r_alu_b       <= w_nxt_b;
                        r_alu_flag_in <= w_chained ? alu_flags : 1'b0;
                    end
                end
                ST_ERR: begin
                    r_err    <= 1'b1;
                    r_result <= '0;
                    r_flag   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_result = r_result;
    assign resp_flag   = r_flag;
    assign resp_err    = r_err;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_flag_in = r_alu_flag_in;
    assign alu_control = r_alu_control;

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wide_sequencer
// Description : Directed self-checking bench for alu_wide_sequencer with a
//               behavioural slice ALU and a queue of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wide_sequencer;
    import alu_pkg::*;

    localparam int ANCHO    = 4;
    localparam int PALABRAS = 4;
    localparam int W        = ANCHO * PALABRAS;

    typedef struct {
        logic [W-1:0] res;
        logic         flag;
        logic         err;
        int           lat;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             req_valid = 1'b0;
    logic [3:0]       req_op    = '0;
    logic [W-1:0]     req_a     = '0;
    logic [W-1:0]     req_b     = '0;
    logic             req_flag  = 1'b0;
    logic             resp_ready = 1'b0;
    logic             req_ready;
    logic             resp_valid;
    logic [W-1:0]     resp_result;
    logic             resp_flag;
    logic             resp_err;
    logic [ANCHO-1:0] alu_a;
    logic [ANCHO-1:0] alu_b;
    logic             alu_flag_in;
    logic [3:0]       alu_control;
    logic [ANCHO-1:0] alu_result;
    logic             alu_flags;

    int n_vec = 0;
    int n_err = 0;
    int n_issue = 0;
    int n_flagin_hi = 0;
    logic [ANCHO-1:0] q_alu_a [$];
    exp_t exp_q [$];
    int last_issue, last_flagin, last_q0;

    alu_wide_sequencer #(.ancho(ANCHO), .palabras(PALABRAS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_flag    (req_flag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flag   (resp_flag),
        .resp_err    (resp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_flag_in (alu_flag_in),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags)
    );

    always #5 clk = ~clk;

    // Slice ALU; logic ops report a zero flag the sequencer must not pass on.
    always_comb begin
        alu_result = '0;
        alu_flags  = 1'b0;
        case (alu_control)
            4'd0: begin alu_result = alu_a & alu_b; alu_flags = ~|alu_result; end
            4'd1: begin alu_result = alu_a | alu_b; alu_flags = ~|alu_result; end
            4'd2: {alu_flags, alu_result} = 5'(alu_a) + 5'(alu_b) + 5'(alu_flag_in);
            4'd5: begin alu_result = ~alu_a;        alu_flags = ~|alu_result; end
            4'd7: begin alu_result = alu_a ^ alu_b; alu_flags = ~|alu_result; end
            4'd8: begin alu_result = {alu_a[ANCHO-2:0], alu_flag_in}; alu_flags = alu_a[ANCHO-1]; end
            4'd9: begin alu_result = {alu_flag_in, alu_a[ANCHO-1:1]}; alu_flags = alu_a[0]; end
            default: ;
        endcase
    end

    // Record every slice the sequencer presents with a nonzero control code.
    always @(negedge clk) begin
        if (alu_control != 4'd0) begin
            n_issue++;
            q_alu_a.push_back(alu_a);
            if (alu_flag_in) n_flagin_hi++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic f);
        exp_t e;
        logic [W:0] sum;
        e.res = '0; e.flag = 1'b0; e.err = 1'b0; e.lat = PALABRAS + 1;
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd5: e.res = ~a;
            4'd7: e.res = a ^ b;
            4'd2: begin
                sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, f};
                e.res = sum[W-1:0]; e.flag = sum[W];
            end
            4'd8: begin e.res = {a[W-2:0], f}; e.flag = a[W-1]; end
            4'd9: begin e.res = {f, a[W-1:1]}; e.flag = a[0];   end
            default: begin e.err = 1'b1; e.lat = 2; end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic f, input int hold);
        exp_t e;
        int   lat;
        int   guard;
        int   i0, f0, q0;
        exp_q.push_back(model(op, a, b, f));
        i0 = n_issue; f0 = n_flagin_hi; q0 = q_alu_a.size();
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_flag = f;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_flag = 1'b0;
        check({tag, " ready_busy"}, 32'(req_ready), 32'd0);
        while (!resp_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        e = exp_q.pop_front();
        check({tag, " valid"},   32'(resp_valid),  32'd1);
        check({tag, " latency"}, 32'(lat),         32'(e.lat));
        check({tag, " result"},  32'(resp_result), 32'(e.res));
        check({tag, " flag"},    32'(resp_flag),   32'(e.flag));
        check({tag, " err"},     32'(resp_err),    32'(e.err));
        last_issue  = n_issue - i0;
        last_flagin = n_flagin_hi - f0;
        last_q0     = q0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            check({tag, " hold_valid"},  32'(resp_valid),  32'd1);
            check({tag, " hold_result"}, 32'(resp_result), 32'(e.res));
            check({tag, " hold_flag"},   32'(resp_flag),   32'(e.flag));
            check({tag, " hold_ready"},  32'(req_ready),   32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " post_ready"}, 32'(req_ready),  32'd1);
        check({tag, " post_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] rs_a;
        // Asynchronous reset: outputs must settle without a clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst req_ready",   32'(req_ready),   32'd1);
        check("rst resp_valid",  32'(resp_valid),  32'd0);
        check("rst resp_result", 32'(resp_result), 32'd0);
        check("rst resp_flag",   32'(resp_flag),   32'd0);
        check("rst resp_err",    32'(resp_err),    32'd0);
        check("rst alu_ctl",     32'(alu_control), 32'd0);
        check("rst alu_a",       32'(alu_a),       32'd0);
        check("rst alu_b",       32'(alu_b),       32'd0);
        check("rst alu_fin",     32'(alu_flag_in), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_ffff", c_op_add, 16'hFFFF, 16'h0001, 1'b0, 0);
        check("add_ffff slices", 32'(last_issue), 32'(PALABRAS));

        run_op("lsh", c_op_lshift, 16'h8001, 16'h0000, 1'b1, 0);

        rs_a = 16'h8001;
        run_op("rsh", c_op_rshift, rs_a, 16'h0000, 1'b0, 0);
        check("rsh slices", 32'(last_issue), 32'(PALABRAS));
        for (int k = 0; k < PALABRAS; k++)
            check("rsh order", 32'(q_alu_a[last_q0 + k]), 32'(rs_a[(PALABRAS-1-k)*ANCHO +: ANCHO]));

        run_op("xor", c_op_xor, 16'hA5A5, 16'h0FF0, 1'b1, 0);
        check("xor slices",  32'(last_issue),  32'(PALABRAS));
        check("xor flag_in", 32'(last_flagin), 32'd0);

        run_op("and_zero", c_op_and, 16'hF0F0, 16'h0F0F, 1'b1, 0);
        run_op("or",  c_op_or,  16'h1200, 16'h0034, 1'b0, 0);
        run_op("not", c_op_not, 16'h0F0F, 16'hFFFF, 1'b1, 0);
        check("not flag_in", 32'(last_flagin), 32'd0);
        run_op("add_cin", c_op_add, 16'h8000, 16'h8000, 1'b1, 0);

        run_op("err4", 4'd4, 16'h1234, 16'h5678, 1'b1, 0);
        check("err4 no_issue", 32'(last_issue), 32'd0);
        run_op("err15", 4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        check("err15 no_issue", 32'(last_issue), 32'd0);

        run_op("hold_add", c_op_add, 16'h1234, 16'h4321, 1'b1, 3);

        // Abort in the third ISSUE cycle; the partial result is nonzero there.
        req_valid = 1'b1; req_op = c_op_add; req_a = 16'h1111; req_b = 16'h2222; req_flag = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("abort mid_busy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort req_ready",   32'(req_ready),   32'd1);
        check("abort resp_valid",  32'(resp_valid),  32'd0);
        check("abort resp_result", 32'(resp_result), 32'd0);
        check("abort resp_flag",   32'(resp_flag),   32'd0);
        check("abort resp_err",    32'(resp_err),    32'd0);
        check("abort alu_ctl",     32'(alu_control), 32'd0);
        check("abort alu_a",       32'(alu_a),       32'd0);
        check("abort alu_b",       32'(alu_b),       32'd0);
        check("abort alu_fin",     32'(alu_flag_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort no_resp", 32'(resp_valid), 32'd0);
        run_op("after_rst", c_op_add, 16'h0001, 16'h0001, 1'b0, 0);

        check("queue empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
